cache_line_ram: RTL and testbench
=================================

CACHE_LINE_RAM -- requirements
Module: cache_line_ram

Interface
REQ-001 Parameter LINE_W, default 532, SHALL set the width of one cache line (bits per word).
REQ-002 Parameter ADDR_W, default 10, SHALL set the address width; DEPTH = 2**ADDR_W lines.
REQ-003 Parameter SEG_W, default 532, SHALL set the width of one write segment; LINE_W % SEG_W != 0 SHALL be an elaboration error; NSEG = LINE_W/SEG_W.
REQ-004 Parameter OUT_REG, default 0, SHALL add one output register stage to both read ports when set to 1.
REQ-005 Parameter INIT_VAL, default 0 (LINE_W bits), SHALL set the value written to every line by the clear sweep.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 flush  in  1  request to re-run the clear sweep over all lines.
REQ-009 data_we  in  NSEG  data-port per-segment write enable; bit i covers bits [i*SEG_W +: SEG_W].
REQ-010 data_addr  in  ADDR_W  data-port line address.
REQ-011 data_in  in  LINE_W  data-port write data.
REQ-012 data_out  out  LINE_W  data-port read data.
REQ-013 inst_we, inst_addr, inst_in, inst_out  in/in/in/out  NSEG/ADDR_W/LINE_W/LINE_W  instruction port, same meaning as the data port.
REQ-014 init_done  out  1  high when the clear sweep is finished and both ports are serviced.
REQ-015 collision  out  1  one-cycle pulse flagging a same-address double write.

Function
REQ-016 The FSM SHALL have two states: CLEAR and READY.
REQ-017 CLEAR SHALL write INIT_VAL to line clr_ptr each cycle, incrementing clr_ptr from 0 to DEPTH-1, then go to READY; the sweep takes exactly DEPTH cycles.
REQ-018 In CLEAR, port writes SHALL be dropped, read outputs SHALL stage 0, init_done SHALL be 0, and flush SHALL be ignored.
REQ-019 In READY, flush=1 SHALL reset clr_ptr to 0 and enter CLEAR next cycle; port writes in the flush cycle itself SHALL be performed.
REQ-020 In READY, each port SHALL write only the segments whose write-enable bit is set; the other segments keep their value.
REQ-021 Reads SHALL be read-first: a read returns the line content before any write in the same cycle, on both the writing port and the other port.
REQ-022 Read latency from address to output SHALL be 1 cycle with OUT_REG=0 and 2 cycles with OUT_REG=1; outputs SHALL update every cycle, independent of write enables.
REQ-023 If both ports write the same address in one cycle, for every segment enabled on both ports the data port SHALL win.
REQ-024 Segments enabled on only one port SHALL take that port's data.
REQ-025 A same-address double write with any overlapping enabled segment SHALL pulse collision high for the following cycle.
REQ-026 collision SHALL be 0 in CLEAR and in every cycle without an overlapping double write.
REQ-027 init_done SHALL rise in the first READY cycle, aligned with the first cycle whose writes take effect.

Reset
REQ-028 rst=1 SHALL immediately force state=CLEAR, clr_ptr=0, data_out=0, inst_out=0 (all output-stage registers 0), init_done=0 and collision=0.
REQ-029 The array contents SHALL not be reset by rst; stale lines are overwritten by the sweep.
REQ-030 rst asserted mid-sweep SHALL restart the sweep from line 0 when rst deasserts.
REQ-031 rst asserted in READY SHALL leave no write from the rst cycle committed.

Verification
REQ-032 Release rst, defaults: init_done=0 for 1024 cycles then 1; a read of any address returns 0.
REQ-033 READY, data_we=1, addr 5, data 0xABC; next cycle inst read addr 5: data_out=0xABC after 1 cycle, inst_out=0xABC after 1 cycle.
REQ-034 Both ports write addr 7 (data 0x1, inst 0x2) in one cycle: line 7 reads 0x1 and collision pulses for one cycle. Different addresses: no pulse.
REQ-035 SEG_W=133, data_we=4'b0010, addr 3, data all-ones over a zeroed line: only bits [265:133] become 1.
REQ-036 flush in READY, then rst at sweep cycle 500: init_done stays 0; after release the sweep restarts at 0 and takes 1024 cycles.
REQ-037 OUT_REG=1, write-then-read of addr 9: data appears 2 cycles after the read address; a same-cycle read returns the old value.

Source files
------------

// File: rtl/cache_line_ram.sv
// Dual-port cache line RAM with a segment-granular write path and a power-up/flush clear sweep.
// Both ports read-first; the data port wins on overlapping same-address segment writes.
module cache_line_ram #(
  parameter int                LINE_W   = 532,
  parameter int                ADDR_W   = 10,
  parameter int                SEG_W    = 532,
  parameter int                OUT_REG  = 0,
  parameter logic [LINE_W-1:0] INIT_VAL = '0,
  localparam int               NSEG     = LINE_W / SEG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [NSEG-1:0]   data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [LINE_W-1:0] data_in,
  output logic [LINE_W-1:0] data_out,
  input  logic [NSEG-1:0]   inst_we,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [LINE_W-1:0] inst_in,
  output logic [LINE_W-1:0] inst_out,
  output logic              init_done,
  output logic              collision
);

  localparam int DEPTH = 2 ** ADDR_W;

  if (LINE_W % SEG_W != 0) begin : g_seg_check
    $error("cache_line_ram: LINE_W must be a multiple of SEG_W");
  end

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_nxt;
  logic              clr_we;
  logic              port_we_en;
  logic              overlap;

  logic [LINE_W-1:0] mem [DEPTH];

  logic [LINE_W-1:0] data_rd_p0;
  logic [LINE_W-1:0] inst_rd_p0;
  logic              coll_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    clr_we      = 1'b0;
    port_we_en  = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we      = 1'b1;
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == {ADDR_W{1'b1}}) begin
          state_nxt = READY;
        end
      end
      READY: begin
        port_we_en = 1'b1;
        if (flush) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign overlap = (data_addr == inst_addr) && (|(data_we & inst_we));

  // Array: inst segments are written first so the data port's later assignment wins on overlap.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ptr] <= INIT_VAL;
    end
    if (port_we_en) begin
      for (int s = 0; s < NSEG; s++) begin
        if (inst_we[s]) begin
          mem[inst_addr][s*SEG_W +: SEG_W] <= inst_in[s*SEG_W +: SEG_W];
        end
      end
      for (int s = 0; s < NSEG; s++) begin
        if (data_we[s]) begin
          mem[data_addr][s*SEG_W +: SEG_W] <= data_in[s*SEG_W +: SEG_W];
        end
      end
    end
  end

  // Stage p0: read-first array read, zero while the sweep is running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_rd_p0 <= '0;
      inst_rd_p0 <= '0;
      coll_p0    <= 1'b0;
    end else begin
      data_rd_p0 <= (state == READY) ? mem[data_addr] : '0;
      inst_rd_p0 <= (state == READY) ? mem[inst_addr] : '0;
      coll_p0    <= port_we_en & overlap;
    end
  end

  // Stage p1: optional output register.
  if (OUT_REG != 0) begin : g_out_reg
    logic [LINE_W-1:0] data_rd_p1;
    logic [LINE_W-1:0] inst_rd_p1;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_rd_p1 <= '0;
        inst_rd_p1 <= '0;
      end else begin
        data_rd_p1 <= data_rd_p0;
        inst_rd_p1 <= inst_rd_p0;
      end
    end

    assign data_out = data_rd_p1;
    assign inst_out = inst_rd_p1;
  end else begin : g_no_out_reg
    assign data_out = data_rd_p0;
    assign inst_out = inst_rd_p0;
  end

  // A collision seen in a flush cycle is suppressed because the next cycle is already CLEAR.
  assign collision = coll_p0 & (state == READY);
  assign init_done = (state == READY);

endmodule

// File: tb/tb_cache_line_ram.sv
// Randomized bench for cache_line_ram: two instances (OUT_REG 0 and 1) share stimulus
// and are compared every cycle against a line-array reference model.
module tb_cache_line_ram;

  localparam int LW    = 532;
  localparam int AW    = 10;
  localparam int SW    = 133;
  localparam int NS    = LW / SW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic [NS-1:0] data_we = '0;
  logic [NS-1:0] inst_we = '0;
  logic [AW-1:0] data_addr = '0;
  logic [AW-1:0] inst_addr = '0;
  logic [LW-1:0] data_in = '0;
  logic [LW-1:0] inst_in = '0;
  logic [LW-1:0] d_out0, i_out0, d_out1, i_out1;
  logic          done0, done1, coll0, coll1;

  int checks = 0;
  int errors = 0;

  logic [LW-1:0] m_mem [DEPTH];
  bit            m_ready;
  int            m_left;
  logic [LW-1:0] e0_d, e0_i, e1_d, e1_i;
  bit            e_coll;

  always #5 clk = ~clk;

  cache_line_ram #(.LINE_W(LW), .ADDR_W(AW), .SEG_W(SW), .OUT_REG(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .data_we(data_we), .data_addr(data_addr), .data_in(data_in), .data_out(d_out0),
    .inst_we(inst_we), .inst_addr(inst_addr), .inst_in(inst_in), .inst_out(i_out0),
    .init_done(done0), .collision(coll0)
  );

  cache_line_ram #(.LINE_W(LW), .ADDR_W(AW), .SEG_W(SW), .OUT_REG(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .data_we(data_we), .data_addr(data_addr), .data_in(data_in), .data_out(d_out1),
    .inst_we(inst_we), .inst_addr(inst_addr), .inst_in(inst_in), .inst_out(i_out1),
    .init_done(done1), .collision(coll1)
  );

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] r = '0;
    for (int i = 0; i < (LW + 31) / 32; i++) r = {r[LW-33:0], 32'($urandom())};
    return r;
  endfunction

  task automatic model_reset();
    m_ready = 1'b0;
    m_left  = DEPTH;
    e0_d = '0; e0_i = '0; e1_d = '0; e1_i = '0;
    e_coll = 1'b0;
  endtask

  task automatic check_outputs();
    check("data_out0", d_out0, e0_d);
    check("inst_out0", i_out0, e0_i);
    check("data_out1", d_out1, e1_d);
    check("inst_out1", i_out1, e1_i);
    check("collision0", coll0, e_coll);
    check("collision1", coll1, e_coll);
    check("init_done0", done0, m_ready);
    check("init_done1", done1, m_ready);
  endtask

  // One clock: predict from current inputs, advance the clock, compare.
  task automatic step();
    logic [LW-1:0] rd_d, rd_i;
    bit was_ready, ovl;
    was_ready = m_ready;
    rd_d = m_ready ? m_mem[data_addr] : '0;
    rd_i = m_ready ? m_mem[inst_addr] : '0;
    ovl  = (data_addr == inst_addr) && ((data_we & inst_we) != '0);
    if (m_ready) begin
      for (int s = 0; s < NS; s++)
        if (inst_we[s]) m_mem[inst_addr][s*SW +: SW] = inst_in[s*SW +: SW];
      for (int s = 0; s < NS; s++)
        if (data_we[s]) m_mem[data_addr][s*SW +: SW] = data_in[s*SW +: SW];
      if (flush) begin
        m_ready = 1'b0;
        m_left  = DEPTH;
      end
    end else begin
      m_mem[DEPTH - m_left] = '0;
      m_left--;
      if (m_left == 0) m_ready = 1'b1;
    end
    e1_d = e0_d; e1_i = e0_i;
    e0_d = rd_d; e0_i = rd_i;
    e_coll = was_ready && ovl && m_ready;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    flush = 1'b0; data_we = '0; inst_we = '0;
  endtask

  task automatic rand_inputs(input bit allow_flush);
    data_we   = NS'($urandom());
    inst_we   = NS'($urandom());
    data_addr = AW'($urandom_range(0, 15));
    inst_addr = ($urandom_range(0, 2) == 0) ? data_addr : AW'($urandom_range(0, 15));
    data_in   = rnd_line();
    inst_in   = rnd_line();
    flush     = allow_flush && ($urandom_range(0, 7) == 0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (n) begin
      @(posedge clk);
      #1;
      check_outputs();
    end
    rst = 1'b0;
  endtask

  // Drives random (to-be-dropped) traffic during the sweep and measures its length.
  task automatic wait_sweep(input string tag);
    int n = 0;
    while (done0 !== 1'b1 && n < DEPTH + 16) begin
      rand_inputs(1'b1);
      step();
      n++;
    end
    idle();
    check(tag, LW'(n), LW'(DEPTH));
  endtask

  initial begin
    logic [LW-1:0] v, exp;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();
    #1;
    do_reset(3);
    wait_sweep("sweep_len_power_up");

    idle();
    data_addr = AW'($urandom_range(100, DEPTH - 1));
    inst_addr = AW'($urandom_range(100, DEPTH - 1));
    step();
    check("cleared_data", d_out0, '0);
    check("cleared_inst", i_out0, '0);

    idle(); data_we = '1; data_addr = 5; data_in = LW'(12'hABC);
    step();
    idle(); data_addr = 5; inst_addr = 5;
    step();
    check("wr5_data_rd", d_out0, LW'(12'hABC));
    check("wr5_inst_rd", i_out0, LW'(12'hABC));

    idle(); data_we = '1; inst_we = '1; data_addr = 7; inst_addr = 7;
    data_in = LW'(1); inst_in = LW'(2);
    step();
    check("coll_pulse", coll0, 1'b1);
    idle(); data_addr = 7; inst_addr = 7;
    step();
    check("coll_data_wins", d_out0, LW'(1));
    check("coll_one_cycle", coll0, 1'b0);
    idle(); data_we = '1; inst_we = '1; data_addr = 10; inst_addr = 11;
    step();
    check("no_coll_diff_addr", coll0, 1'b0);

    idle(); data_we = '1; data_addr = 3; data_in = '0;
    step();
    idle(); data_we = 4'b0010; data_addr = 3; data_in = '1;
    step();
    idle(); data_addr = 3;
    step();
    exp = {{(LW - 2*SW){1'b0}}, {SW{1'b1}}, {SW{1'b0}}};
    check("seg1_only", d_out0, exp);

    v = rnd_line();
    idle(); data_we = '1; data_addr = 9; inst_addr = 9; data_in = v;
    step();
    idle(); data_addr = 9; inst_addr = 9;
    step();
    check("outreg_old_data", d_out1, '0);
    check("outreg_old_inst", i_out1, '0);
    step();
    check("outreg_new_data", d_out1, v);
    check("outreg_new_inst", i_out1, v);

    repeat (400) begin
      rand_inputs(1'b0);
      step();
    end

    idle(); flush = 1'b1; data_we = '1; data_addr = 12; data_in = rnd_line();
    step();
    repeat (500) begin
      rand_inputs(1'b1);
      step();
    end
    idle();
    do_reset(2);
    wait_sweep("sweep_len_after_rst");

    repeat (200) begin
      rand_inputs(1'b0);
      step();
    end
    idle(); flush = 1'b1;
    step();
    idle();
    wait_sweep("sweep_len_after_flush");
    repeat (50) begin
      rand_inputs(1'b0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
